// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel pulse scheduler driven by a shared base tick
module tick_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                CLK_IN,
  input  logic                RST_IN,
  input  logic                TICK_IN,
  input  logic                CFG_WE,
  input  logic [CH_W-1:0]     CFG_CH,
  input  logic [PERIOD_W-1:0] CFG_PERIOD,
  input  logic                CFG_ONESHOT,
  input  logic [NUM_CH-1:0]   START,
  input  logic [NUM_CH-1:0]   STOP,
  output logic [NUM_CH-1:0]   PULSE_OUT,
  output logic [NUM_CH-1:0]   ACTIVE,
  output logic [NUM_CH-1:0]   DONE
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ch_state_t;

  // Programmed configuration (takes effect at next start or periodic reload)
  logic [PERIOD_W-1:0] period_q [NUM_CH];
  logic [NUM_CH-1:0]   oneshot_q;

  // Per-channel running state
  ch_state_t           state_q   [NUM_CH];
  ch_state_t           state_d   [NUM_CH];
  logic [PERIOD_W-1:0] cnt_q     [NUM_CH];
  logic [PERIOD_W-1:0] cnt_d     [NUM_CH];
  logic [PERIOD_W-1:0] act_per_q [NUM_CH];
  logic [PERIOD_W-1:0] act_per_d [NUM_CH];
  logic [NUM_CH-1:0]   act_os_q;
  logic [NUM_CH-1:0]   act_os_d;
  logic [NUM_CH-1:0]   pulse_d;
  logic [NUM_CH-1:0]   done_d;

  // Write decode and write-through view used by a start in the same cycle
  logic [NUM_CH-1:0]   cfg_hit;
  logic [PERIOD_W-1:0] eff_per [NUM_CH];
  logic [NUM_CH-1:0]   eff_os;

  // Decode the config write; an out-of-range channel matches nothing
  always_comb begin
    cfg_hit = '0;
    eff_os  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eff_per[i] = period_q[i];
      cfg_hit[i] = CFG_WE && (CFG_CH == CH_W'(i));
      if (cfg_hit[i]) begin
        eff_per[i] = CFG_PERIOD;
        eff_os[i]  = CFG_ONESHOT;
      end else begin
        eff_os[i]  = oneshot_q[i];
      end
    end
  end

  // Configuration registers
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
      end
      oneshot_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_hit[i]) begin
          period_q[i]  <= CFG_PERIOD;
          oneshot_q[i] <= CFG_ONESHOT;
        end
      end
    end
  end

  // Channel next-state: STOP beats START beats TICK; a tick in a start cycle is not counted
  always_comb begin
    act_os_d = act_os_q;
    pulse_d  = '0;
    done_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      act_per_d[i] = act_per_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (START[i] && !STOP[i] && (eff_per[i] != '0)) begin
            state_d[i]   = S_RUN;
            cnt_d[i]     = '0;
            act_per_d[i] = eff_per[i];
            act_os_d[i]  = eff_os[i];
          end
        end
        S_RUN: begin
          if (STOP[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (START[i] && (eff_per[i] != '0)) begin
            cnt_d[i]     = '0;
            act_per_d[i] = eff_per[i];
            act_os_d[i]  = eff_os[i];
          end else if (TICK_IN) begin
            if (cnt_q[i] == (act_per_q[i] - PERIOD_W'(1))) begin
              pulse_d[i] = 1'b1;
              cnt_d[i]   = '0;
              if (act_os_q[i]) begin
                state_d[i] = S_IDLE;
                done_d[i]  = 1'b1;
              end else if (period_q[i] == '0) begin
                // Reprogrammed to 0 while running: finish this interval, then stop quietly
                state_d[i] = S_IDLE;
              end else begin
                act_per_d[i] = period_q[i];
                act_os_d[i]  = oneshot_q[i];
              end
            end else begin
              cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
            end
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Channel state and registered outputs
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= S_IDLE;
        cnt_q[i]     <= '0;
        act_per_q[i] <= '0;
      end
      act_os_q  <= '0;
      PULSE_OUT <= '0;
      ACTIVE    <= '0;
      DONE      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= state_d[i];
        cnt_q[i]     <= cnt_d[i];
        act_per_q[i] <= act_per_d[i];
        ACTIVE[i]    <= (state_d[i] == S_RUN);
      end
      act_os_q  <= act_os_d;
      PULSE_OUT <= pulse_d;
      DONE      <= done_d;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed self-checking bench for tick_scheduler
module tb_tick_scheduler;

  localparam int NUM_CH   = 4;
  localparam int PERIOD_W = 8;

  logic                CLK_IN;
  logic                RST_IN;
  logic                TICK_IN;
  logic                CFG_WE;
  logic [1:0]          CFG_CH;
  logic [PERIOD_W-1:0] CFG_PERIOD;
  logic                CFG_ONESHOT;
  logic [NUM_CH-1:0]   START;
  logic [NUM_CH-1:0]   STOP;
  logic [NUM_CH-1:0]   PULSE_OUT;
  logic [NUM_CH-1:0]   ACTIVE;
  logic [NUM_CH-1:0]   DONE;

  int checks = 0;
  int errors = 0;
  logic seen;

  tick_scheduler #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
    .CLK_IN(CLK_IN),
    .RST_IN(RST_IN),
    .TICK_IN(TICK_IN),
    .CFG_WE(CFG_WE),
    .CFG_CH(CFG_CH),
    .CFG_PERIOD(CFG_PERIOD),
    .CFG_ONESHOT(CFG_ONESHOT),
    .START(START),
    .STOP(STOP),
    .PULSE_OUT(PULSE_OUT),
    .ACTIVE(ACTIVE),
    .DONE(DONE)
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic tick();
    TICK_IN = 1'b1;
    step();
    TICK_IN = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [PERIOD_W-1:0] per, input logic os);
    CFG_WE = 1'b1; CFG_CH = ch; CFG_PERIOD = per; CFG_ONESHOT = os;
    step();
    CFG_WE = 1'b0;
  endtask

  task automatic start(input logic [NUM_CH-1:0] m);
    START = m;
    step();
    START = '0;
  endtask

  task automatic stop(input logic [NUM_CH-1:0] m);
    STOP = m;
    step();
    STOP = '0;
  endtask

  initial begin
    RST_IN = 1'b1; TICK_IN = 1'b0; CFG_WE = 1'b0; CFG_CH = '0;
    CFG_PERIOD = '0; CFG_ONESHOT = 1'b0; START = '0; STOP = '0;
    idle(2);
    chk("reset_pulse", PULSE_OUT, 0);
    chk("reset_active", ACTIVE, 0);
    chk("reset_done", DONE, 0);
    RST_IN = 1'b0;
    step();

    // Max period 255 with tick held high: pulse on tick 255 and 510 only
    cfg(2'd0, 8'd255, 1'b0);
    start(4'b0001);
    TICK_IN = 1'b1;
    seen = 1'b0;
    repeat (254) begin step(); seen = seen | PULSE_OUT[0]; end
    chk("max_no_early", seen, 0);
    step();
    chk("max_pulse1", PULSE_OUT[0], 1);
    seen = 1'b0;
    repeat (254) begin step(); seen = seen | PULSE_OUT[0]; end
    chk("max_wrap_no_early", seen, 0);
    step();
    chk("max_pulse2", PULSE_OUT[0], 1);
    TICK_IN = 1'b0;
    stop(4'b0001);
    chk("max_stopped", ACTIVE[0], 0);

    // ch0 period 3 periodic, tick every 10 cycles
    cfg(2'd0, 8'd3, 1'b0);
    start(4'b0001);
    chk("p3_active_start", ACTIVE[0], 1);
    for (int k = 1; k <= 9; k++) begin
      idle(9);
      chk("p3_gap", PULSE_OUT[0], 0);
      tick();
      chk("p3_pulse", PULSE_OUT[0], (k % 3 == 0) ? 1 : 0);
      chk("p3_active", ACTIVE[0], 1);
      chk("p3_done", DONE[0], 0);
    end
    stop(4'b0001);
    chk("p3_stopped", ACTIVE[0], 0);

    // ch1 period 2 one-shot
    cfg(2'd1, 8'd2, 1'b1);
    start(4'b0010);
    chk("os_active", ACTIVE[1], 1);
    tick();
    chk("os_t1_pulse", PULSE_OUT[1], 0);
    tick();
    chk("os_t2_pulse", PULSE_OUT[1], 1);
    chk("os_t2_done", DONE[1], 1);
    chk("os_t2_active", ACTIVE[1], 0);
    step();
    chk("os_done_once", DONE[1], 0);
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | PULSE_OUT[1] | ACTIVE[1] | DONE[1]; idle(1); end
    chk("os_quiet", seen, 0);

    // ch0 period 4, reprogrammed to 2 after tick 1
    cfg(2'd0, 8'd4, 1'b0);
    start(4'b0001);
    tick();
    cfg(2'd0, 8'd2, 1'b0);
    tick();
    chk("rp_t2", PULSE_OUT[0], 0);
    tick();
    chk("rp_t3", PULSE_OUT[0], 0);
    tick();
    chk("rp_t4", PULSE_OUT[0], 1);
    tick();
    chk("rp_t5", PULSE_OUT[0], 0);
    tick();
    chk("rp_t6", PULSE_OUT[0], 1);
    tick();
    chk("rp_t7", PULSE_OUT[0], 0);
    tick();
    chk("rp_t8", PULSE_OUT[0], 1);
    stop(4'b0001);

    // ch2 period 5, STOP coincident with expiring tick
    cfg(2'd2, 8'd5, 1'b0);
    start(4'b0100);
    seen = 1'b0;
    repeat (4) begin tick(); seen = seen | PULSE_OUT[2]; end
    chk("st_no_early", seen, 0);
    TICK_IN = 1'b1; STOP = 4'b0100;
    step();
    TICK_IN = 1'b0; STOP = '0;
    chk("st_no_pulse", PULSE_OUT[2], 0);
    chk("st_inactive", ACTIVE[2], 0);
    START = 4'b0100; STOP = 4'b0100;
    step();
    START = '0; STOP = '0;
    chk("st_stop_wins", ACTIVE[2], 0);
    tick();
    chk("st_idle_tick", PULSE_OUT[2], 0);

    // ch3 period 0 ignored, then write-through start with period 1
    cfg(2'd3, 8'd0, 1'b0);
    start(4'b1000);
    chk("z_not_active", ACTIVE[3], 0);
    CFG_WE = 1'b1; CFG_CH = 2'd3; CFG_PERIOD = 8'd1; CFG_ONESHOT = 1'b0; START = 4'b1000;
    TICK_IN = 1'b1;
    step();
    CFG_WE = 1'b0; START = '0; TICK_IN = 1'b0;
    chk("wt_active", ACTIVE[3], 1);
    chk("wt_tick_ignored", PULSE_OUT[3], 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wt_pulse", PULSE_OUT[3], 1);
      step();
      chk("wt_gap", PULSE_OUT[3], 0);
    end

    // All channels period 1, started together
    for (int c = 0; c < NUM_CH; c++) cfg(c[1:0], 8'd1, 1'b0);
    start(4'b1111);
    chk("all_active", ACTIVE, 4'b1111);
    tick();
    chk("all_pulse1", PULSE_OUT, 4'b1111);
    step();
    chk("all_gap", PULSE_OUT, 4'b0000);
    TICK_IN = 1'b1;
    step();
    chk("all_cont1", PULSE_OUT, 4'b1111);
    step();
    chk("all_cont2", PULSE_OUT, 4'b1111);
    RST_IN = 1'b1;
    step();
    RST_IN = 1'b0; TICK_IN = 1'b0;
    chk("rst_pulse", PULSE_OUT, 0);
    chk("rst_active", ACTIVE, 0);
    chk("rst_done", DONE, 0);
    start(4'b1111);
    chk("rst_cfg_lost", ACTIVE, 0);
    tick();
    chk("rst_no_pulse", PULSE_OUT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
